// File: rtl/cv32e40p_pkg.sv
// Shared types for the APU arbiter: FSM state encoding and an index-width helper.
package cv32e40p_pkg;

  typedef enum logic [0:0] {
    APU_ARB_IDLE     = 1'b0,
    APU_ARB_WAIT_GNT = 1'b1
  } apu_arb_state_e;

  // Width of an index into n entries; never zero, so NREQ=1-style corner cases still elaborate.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cv32e40p_apu_arbiter_if.sv
// Requester-side and APU-side bundle of the APU arbiter; master = arbiter, slave = cores/APU.
interface cv32e40p_apu_arbiter_if #(
  parameter int NREQ             = 2,
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5
);
  logic [NREQ-1:0]                         req_i;
  logic [NREQ-1:0]                         gnt_o;
  logic [NREQ-1:0][APU_NARGS_CPU-1:0][31:0] operands_i;
  logic [NREQ-1:0][APU_WOP_CPU-1:0]        op_i;
  logic [NREQ-1:0][APU_NDSFLAGS_CPU-1:0]   flags_i;
  logic [NREQ-1:0]                         rvalid_o;
  logic [31:0]                             result_o;
  logic [APU_NUSFLAGS_CPU-1:0]             rflags_o;

  logic                                    apu_req_o;
  logic                                    apu_gnt_i;
  logic [APU_NARGS_CPU-1:0][31:0]          apu_operands_o;
  logic [APU_WOP_CPU-1:0]                  apu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0]             apu_flags_o;
  logic                                    apu_rvalid_i;
  logic [31:0]                             apu_result_i;
  logic [APU_NUSFLAGS_CPU-1:0]             apu_rflags_i;

  modport master (
    input  req_i, operands_i, op_i, flags_i,
    input  apu_gnt_i, apu_rvalid_i, apu_result_i, apu_rflags_i,
    output gnt_o, rvalid_o, result_o, rflags_o,
    output apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
  );

  modport slave (
    output req_i, operands_i, op_i, flags_i,
    output apu_gnt_i, apu_rvalid_i, apu_result_i, apu_rflags_i,
    input  gnt_o, rvalid_o, result_o, rflags_o,
    input  apu_req_o, apu_operands_o, apu_op_o, apu_flags_o
  );

endinterface

// File: rtl/cv32e40p_apu_arb_tagfifo.sv
// In-order tag FIFO remembering which requester owns each outstanding APU transaction.
module cv32e40p_apu_arb_tagfifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is exactly modulo DEPTH.
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; an entry is only ever read after it was written, and count gates that.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU among NREQ cores with in-order response routing.
// Optional per-requester stall counters are built when CV32E40P_APU_ARB_PERF_EN is defined.
module cv32e40p_apu_arbiter
  import cv32e40p_pkg::*;
#(
  parameter int NREQ             = 2,
  parameter int APU_NARGS_CPU    = 3,
  parameter int APU_WOP_CPU      = 6,
  parameter int APU_NDSFLAGS_CPU = 15,
  parameter int APU_NUSFLAGS_CPU = 5,
  parameter int DEPTH            = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  cv32e40p_apu_arbiter_if.master    bus,
  output logic                      busy_o,
  output logic                      err_o
`ifdef CV32E40P_APU_ARB_PERF_EN
  ,
  output logic [NREQ-1:0][15:0]     stall_cnt_o
`endif
);
  localparam int TAG_W = idx_width(NREQ);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  apu_arb_state_e   state_q, state_d;
  logic [TAG_W-1:0] locked_q, locked_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0] rr_pick, sel, head_tag;
  logic             want, accept, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // First asserted request at or after rr_ptr; scanning downward leaves the nearest one.
  always_comb begin
    int idx;
    idx     = 0;
    rr_pick = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req_i[idx]) rr_pick = TAG_W'(idx);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    rr_ptr_d = rr_ptr_q;
    sel      = (state_q == APU_ARB_WAIT_GNT) ? locked_q : rr_pick;
    want     = (state_q == APU_ARB_WAIT_GNT) | (|bus.req_i);
    bus.apu_req_o = want & ~fifo_full & ~rst;
    accept   = bus.apu_req_o & bus.apu_gnt_i;

    case (state_q)
      APU_ARB_IDLE: begin
        if (bus.apu_req_o && !bus.apu_gnt_i) begin
          state_d  = APU_ARB_WAIT_GNT;
          locked_d = sel;
        end
      end
      APU_ARB_WAIT_GNT: begin
        if (accept) state_d = APU_ARB_IDLE;
      end
      default: state_d = APU_ARB_IDLE;
    endcase

    if (accept) rr_ptr_d = (int'(sel) == NREQ - 1) ? '0 : sel + TAG_W'(1);

    bus.gnt_o = '0;
    if (accept) bus.gnt_o[sel] = 1'b1;

    bus.apu_operands_o = bus.operands_i[sel];
    bus.apu_op_o       = bus.op_i[sel];
    bus.apu_flags_o    = bus.flags_i[sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= APU_ARB_IDLE;
      locked_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  cv32e40p_apu_arb_tagfifo #(
    .WIDTH (TAG_W),
    .DEPTH (DEPTH)
  ) u_tagfifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (sel),
    .pop       (pop),
    .pop_data  (head_tag),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A response with nothing outstanding is a protocol error and is otherwise dropped.
  assign pop = bus.apu_rvalid_i & ~fifo_empty & ~rst;

  always_comb begin
    bus.rvalid_o = '0;
    if (pop) bus.rvalid_o[head_tag] = 1'b1;
  end

  assign bus.result_o = bus.apu_result_i;
  assign bus.rflags_o = bus.apu_rflags_i;
  assign busy_o       = (fifo_count != '0) & ~rst;

  always_ff @(posedge clk) begin
    if (rst)                                 err_o <= 1'b0;
    else if (bus.apu_rvalid_i && fifo_empty) err_o <= 1'b1;
  end

`ifdef CV32E40P_APU_ARB_PERF_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_stall
    always_ff @(posedge clk) begin
      if (rst) begin
        stall_cnt_o[i] <= '0;
      end else if (bus.req_i[i] && !bus.gnt_o[i] && stall_cnt_o[i] != 16'hFFFF) begin
        stall_cnt_o[i] <= stall_cnt_o[i] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_cv32e40p_apu_arbiter;
  localparam int NREQ  = 2;
  localparam int NARGS = 3;
  localparam int WOP   = 6;
  localparam int NDS   = 15;
  localparam int NUS   = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy, err;
`ifdef CV32E40P_APU_ARB_PERF_EN
  logic [NREQ-1:0][15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  cv32e40p_apu_arbiter_if #(
    .NREQ (NREQ), .APU_NARGS_CPU (NARGS), .APU_WOP_CPU (WOP),
    .APU_NDSFLAGS_CPU (NDS), .APU_NUSFLAGS_CPU (NUS)
  ) bus ();

  cv32e40p_apu_arbiter #(
    .NREQ (NREQ), .APU_NARGS_CPU (NARGS), .APU_WOP_CPU (WOP),
    .APU_NDSFLAGS_CPU (NDS), .APU_NUSFLAGS_CPU (NUS), .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy_o (busy),
    .err_o  (err)
`ifdef CV32E40P_APU_ARB_PERF_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending locked requester, round-robin start, queue of owner tags.
  int  m_pending = -1;
  int  m_rr      = 0;
  int  m_q[$];
  bit  m_err     = 1'b0;
  int  m_stall[NREQ];

  logic [NREQ-1:0] obs_gnt, obs_rvalid;
  logic            obs_apu_req, obs_busy, obs_err;
  logic [WOP-1:0]  obs_op;
  logic [31:0]     obs_result;

  task automatic step();
    int              sel;
    bit              want, acc, pop;
    logic            e_req;
    logic [NREQ-1:0] e_gnt, e_rvalid, req_seen;
    bit              rv_seen;
    #2;
    req_seen = bus.req_i;
    rv_seen  = bus.apu_rvalid_i;
    if (m_pending >= 0) begin
      sel  = m_pending;
      want = 1'b1;
    end else begin
      sel  = m_rr;
      want = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (!want && req_seen[(m_rr + k) % NREQ]) begin
          sel  = (m_rr + k) % NREQ;
          want = 1'b1;
        end
      end
    end
    e_req = !rst && want && (m_q.size() < DEPTH);
    acc   = e_req && bus.apu_gnt_i;
    pop   = !rst && rv_seen && (m_q.size() > 0);
    e_gnt = '0;
    if (acc) e_gnt[sel] = 1'b1;
    e_rvalid = '0;
    if (pop) e_rvalid[m_q[0]] = 1'b1;

    obs_gnt     = bus.gnt_o;
    obs_rvalid  = bus.rvalid_o;
    obs_apu_req = bus.apu_req_o;
    obs_busy    = busy;
    obs_err     = err;
    obs_op      = bus.apu_op_o;
    obs_result  = bus.result_o;

    check("apu_req", bus.apu_req_o, e_req);
    check("gnt", bus.gnt_o, e_gnt);
    check("rvalid", bus.rvalid_o, e_rvalid);
    check("busy", busy, !rst && (m_q.size() != 0));
    if (!rst) check("err", err, m_err);
    if (e_req) begin
      check("apu_op", bus.apu_op_o, bus.op_i[sel]);
      check("apu_operands", bus.apu_operands_o, bus.operands_i[sel]);
      check("apu_flags", bus.apu_flags_o, bus.flags_i[sel]);
    end
    if (pop) begin
      check("result", bus.result_o, bus.apu_result_i);
      check("rflags", bus.rflags_o, bus.apu_rflags_i);
    end
`ifdef CV32E40P_APU_ARB_PERF_EN
    for (int i = 0; i < NREQ; i++) check("stall_cnt", stall_cnt[i], m_stall[i]);
`endif

    @(posedge clk);
    if (rst) begin
      m_pending = -1;
      m_rr      = 0;
      m_q.delete();
      m_err     = 1'b0;
      for (int i = 0; i < NREQ; i++) m_stall[i] = 0;
    end else begin
      if (rv_seen && m_q.size() == 0) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(sel);
        m_pending = -1;
        m_rr      = (sel + 1) % NREQ;
      end else if (e_req) begin
        m_pending = sel;
      end
      for (int i = 0; i < NREQ; i++)
        if (req_seen[i] && !e_gnt[i] && m_stall[i] < 65535) m_stall[i]++;
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_i        = '0;
    bus.apu_gnt_i    = 1'b0;
    bus.apu_rvalid_i = 1'b0;
    bus.apu_result_i = '0;
    bus.apu_rflags_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NARGS; j++) bus.operands_i[i][j] = $urandom;
      bus.op_i[i]    = WOP'($urandom);
      bus.flags_i[i] = NDS'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) m_stall[i] = 0;
    randomize_payload();
    do_reset();

    // Round-robin alternation under a permanent grant.
    bus.req_i = 2'b11; bus.apu_gnt_i = 1'b1;
    step(); check("rr_gnt0", obs_gnt, 2'b01);
    step(); check("rr_gnt1", obs_gnt, 2'b10);
    step(); check("rr_gnt2", obs_gnt, 2'b01);

    // Locked selection stays on requester 1 while requester 0 joins.
    do_reset();
    bus.op_i[0] = 6'h15; bus.op_i[1] = 6'h2A;
    bus.req_i = 2'b10; bus.apu_gnt_i = 1'b0;
    step(); check("lock_op1", obs_op, 6'h2A);
    bus.req_i = 2'b11;
    step(); check("lock_op2", obs_op, 6'h2A);
    step(); check("lock_op3", obs_op, 6'h2A);
    bus.apu_gnt_i = 1'b1;
    step(); check("lock_op4", obs_op, 6'h2A);
    check("lock_gnt4", obs_gnt, 2'b10);

    // Full FIFO gates the request, a pop frees it only on the following cycle.
    do_reset();
    bus.req_i = 2'b01; bus.apu_gnt_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    step(); check("full_req", obs_apu_req, 1'b0);
    bus.apu_rvalid_i = 1'b1;
    step(); check("full_pop_same", obs_apu_req, 1'b0);
    check("full_pop_rv", obs_rvalid, 2'b01);
    bus.apu_rvalid_i = 1'b0;
    step(); check("full_pop_next", obs_apu_req, 1'b1);

    // In-order response routing.
    do_reset();
    bus.req_i = 2'b11; bus.apu_gnt_i = 1'b1;
    repeat (3) step();
    bus.req_i = 2'b00; bus.apu_gnt_i = 1'b0; bus.apu_rvalid_i = 1'b1;
    bus.apu_result_i = 32'h11;
    step(); check("resp0_rv", obs_rvalid, 2'b01); check("resp0_res", obs_result, 32'h11);
    bus.apu_result_i = 32'h22;
    step(); check("resp1_rv", obs_rvalid, 2'b10); check("resp1_res", obs_result, 32'h22);
    bus.apu_result_i = 32'h33;
    step(); check("resp2_rv", obs_rvalid, 2'b01); check("resp2_res", obs_result, 32'h33);

    // Spurious response sets a sticky error; reset clears it and drops outstanding tags.
    step(); check("spur_rv", obs_rvalid, 2'b00);
    bus.apu_rvalid_i = 1'b0;
    step(); check("err_set", obs_err, 1'b1);
    bus.req_i = 2'b11; bus.apu_gnt_i = 1'b1;
    step(); check("err_sticky", obs_err, 1'b1);
    step();
    idle_inputs();
    step(); check("busy_two", obs_busy, 1'b1);
    rst = 1'b1;
    step(); check("busy_in_rst", obs_busy, 1'b0);
    rst = 1'b0;
    step(); check("busy_after_rst", obs_busy, 1'b0);
    check("err_after_rst", obs_err, 1'b0);

`ifdef CV32E40P_APU_ARB_PERF_EN
    do_reset();
    bus.req_i = 2'b11; bus.apu_gnt_i = 1'b0;
    repeat (5) step();
    check("stall_cnt1", stall_cnt[1], 16'd5);
`endif

    // Random traffic; the model tracks everything including reset and spurious responses.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      bus.req_i = NREQ'($urandom);
      if (m_pending >= 0 && $urandom_range(0, 15) != 0) bus.req_i[m_pending] = 1'b1;
      bus.apu_gnt_i    = ($urandom_range(0, 2) != 0);
      bus.apu_rvalid_i = ($urandom_range(0, 2) == 0);
      bus.apu_result_i = $urandom;
      bus.apu_rflags_i = NUS'($urandom);
      randomize_payload();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
